// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit streaming ALU (arith/logic/compare/shift) with a registered result bus and status flags.
// Latency: 1 cycle for every op except DIV with B!=0, which lands WIDTH cycles after accept.
// Backpressure: a held result stays bit-stable while out_ready=0; in_ready drops while dividing or while a result is stuck.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; A, B, ALU_FUN sampled on accept only
//   out_valid/out_ready result handshake
//   result              2*WIDTH result bus
//   carry_out, ovf_flag, zero_flag, dz_flag, unit_sel   flags registered alongside result
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               ovf_flag,
  output logic               zero_flag,
  output logic               dz_flag,
  output logic [3:0]         unit_sel
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int SHW1 = SHW + 1;
  localparam int DW   = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_GT   = 4'b1010;
  localparam logic [3:0] OP_LT   = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_ROL  = 4'b1111;

  localparam logic [SHW:0] WID_S = SHW1'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [DW-1:0]    result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             dz_q;
  logic [3:0]       unit_q;

  // Divider working registers: quo_q starts as the dividend and shifts out
  // MSB-first while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [SHW-1:0]   cnt_q;

  logic             accept;
  logic             div_start;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [DW-1:0]    mul_w;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH-1:0] sra_w;
  logic [WIDTH-1:0] rol_w;

  logic [DW-1:0]    res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             dz_d;
  logic [3:0]       unit_d;

  assign sh    = B[SHW-1:0];
  assign rsh   = WID_S - {1'b0, sh};
  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = {1'b0, A} - {1'b0, B};
  assign mul_w = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign sra_w = $signed(A) >>> sh;
  // For sh==0 the right shift is by WIDTH and contributes nothing.
  assign rol_w = (A << sh) | (A >> rsh);

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dz_d    = 1'b0;
    case (ALU_FUN)
      OP_ADD: begin
        res_d   = {{WIDTH{1'b0}}, add_w[WIDTH-1:0]};
        carry_d = add_w[WIDTH];
        ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};
        carry_d = sub_w[WIDTH];  // borrow
        ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        res_d = mul_w;
        ovf_d = |mul_w[DW-1:WIDTH];
      end
      OP_DIV: begin
        // Only reaches the result register on divide-by-zero.
        res_d = {A, {WIDTH{1'b1}}};
        dz_d  = (B == '0);
      end
      OP_AND:  res_d = {{WIDTH{1'b0}}, A & B};
      OP_OR:   res_d = {{WIDTH{1'b0}}, A | B};
      OP_NAND: res_d = {{WIDTH{1'b0}}, ~(A & B)};
      OP_NOR:  res_d = {{WIDTH{1'b0}}, ~(A | B)};
      OP_NOP:  res_d = '0;
      OP_EQ:   res_d = (A == B) ? DW'(1) : '0;
      OP_GT:   res_d = (A > B)  ? DW'(2) : '0;
      OP_LT:   res_d = (A < B)  ? DW'(3) : '0;
      OP_SHR:  res_d = {{WIDTH{1'b0}}, A >> sh};
      OP_SHL:  res_d = {{WIDTH{1'b0}}, A << sh};
      OP_SRA:  res_d = {{WIDTH{1'b0}}, sra_w};
      OP_ROL:  res_d = {{WIDTH{1'b0}}, rol_w};
      default: res_d = '0;
    endcase
  end

  assign unit_d    = 4'b0001 << ALU_FUN[3:2];
  assign div_start = (ALU_FUN == OP_DIV) && (B != '0);

  // ---------------- restoring divide step ----------------
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  // rem_sh < 2*divisor always, so the top bit of the trial difference is
  // set exactly when the subtraction would go negative.
  assign ge     = ~trial[WIDTH];
  assign rem_d  = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_d  = {quo_q[WIDTH-2:0], ge};

  // ---------------- handshake and control ----------------
  assign in_ready = !RST && (state_q != DIV_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      unit_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            if (div_start) begin
              state_q     <= DIV_RUN;
              out_valid_q <= 1'b0;
              rem_q       <= '0;
              quo_q       <= A;
              dvs_q       <= B;
              cnt_q       <= SHW'(WIDTH - 1);
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              zero_q      <= (res_d == '0);
              dz_q        <= dz_d;
              unit_q      <= unit_d;
            end
          end else if (state_q == HOLD && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        DIV_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= {rem_d, quo_d};
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= ({rem_d, quo_d} == '0);
            dz_q        <= 1'b0;
            unit_q      <= 4'b0001;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign ovf_flag  = ovf_q;
  assign zero_flag = zero_q;
  assign dz_flag   = dz_q;
  assign unit_sel  = unit_q;

endmodule
